program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 144 ++++++++++++++
 tb/tb_program_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time program loader: takes a little-endian byte stream (16-bit word count, then
// 32-bit words), writes the words to instruction memory and holds the core in reset until done.
module program_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count
);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    // Wide enough to hold both the 16-bit count and 2^ADDR_W without truncation.
    localparam int unsigned CMP_W = (ADDR_W + 1 > 17) ? ADDR_W + 1 : 17;
    localparam logic [CMP_W-1:0] MAX_WORDS = CMP_W'(1) << ADDR_W;

    state_t            state, state_next;
    logic [ADDR_W:0]   idx, idx_next, idx_inc;
    logic [1:0]        cnt, cnt_next;
    logic [31:0]       word, word_next;
    logic [7:0]        n_lo, n_lo_next;
    logic [15:0]       n_next;
    logic              fire;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [15:0]       n_hdr;

    assign fire    = byte_valid && byte_ready;
    assign idx_inc = idx + 1'b1;
    assign n_hdr   = {byte_data, n_lo};

    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        word_next  = word;
        n_lo_next  = n_lo;
        n_next     = word_count;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next = HDR0;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
            end
            HDR0: begin
                if (fire) begin
                    n_lo_next  = byte_data;
                    state_next = HDR1;
                end
            end
            HDR1: begin
                if (fire) begin
                    n_next = n_hdr;
                    if (n_hdr == 16'd0)
                        state_next = DONE;
                    else if (CMP_W'(n_hdr) > MAX_WORDS)
                        state_next = ERR;
                    else
                        state_next = DATA;
                end
            end
            DATA: begin
                if (fire) begin
                    word_next[{cnt, 3'b000} +: 8] = byte_data;
                    cnt_next = cnt + 2'd1;
                    if (cnt == 2'd3)
                        state_next = WRITE;
                end
            end
            WRITE: begin
                idx_next = idx_inc;
                if (CMP_W'(idx_inc) == CMP_W'(word_count))
                    state_next = DONE;
                else
                    state_next = DATA;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            word       <= '0;
            n_lo       <= '0;
            word_count <= '0;
            byte_ready <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rst   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            cnt        <= cnt_next;
            word       <= word_next;
            n_lo       <= n_lo_next;
            word_count <= n_next;
            byte_ready <= (state_next == HDR0) || (state_next == HDR1) || (state_next == DATA);
            we_q       <= (state_next == WRITE);
            addr_q     <= (state_next == WRITE) ? idx_next[ADDR_W-1:0] : '0;
            wdata_q    <= (state_next == WRITE) ? word_next : '0;
            core_rst   <= (state_next != DONE);
            busy       <= (state_next == HDR0) || (state_next == HDR1) ||
                          (state_next == DATA) || (state_next == WRITE);
            done       <= (state_next == DONE);
            error      <= (state_next == ERR);
        end
    end

    // Gating by rst keeps a reset that lands on a WRITE cycle from committing the word.
    assign imem_we    = we_q && !rst;
    assign imem_addr  = imem_we ? addr_q : '0;
    assign imem_wdata = imem_we ? wdata_q : '0;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: header handling, word assembly,
// stalls, reset mid-load, start during load and the full 256-word boundary.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_count = 0;
    int wr_base;

    program_loader #(.ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst  (core_rst),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (imem_we === 1'b1) wr_count++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        logic ok;
        ok = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            rdy = byte_ready;
            tick();
            if (rdy) ok = 1'b1;
        end
        byte_valid = 1'b0;
        if (!ok) check("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int unsigned k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    initial begin
        do_reset();
        check("rst_core_rst", core_rst, 1);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_word_count", word_count, 0);

        // Two-word program, no stalls.
        wr_base = wr_count;
        pulse_start();
        check("a_busy_hdr0", busy, 1);
        check("a_ready_hdr0", byte_ready, 1);
        send_byte(8'h02); send_byte(8'h00);
        check("a_word_count", word_count, 2);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0);
        check("a_no_early_we", imem_we, 0);
        send_byte(8'h00);
        check("a_we0", imem_we, 1);
        check("a_addr0", imem_addr, 0);
        check("a_data0", imem_wdata, 32'h00A00513);
        check("a_ready_write", byte_ready, 0);
        send_byte(8'h93); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
        check("a_we1", imem_we, 1);
        check("a_addr1", imem_addr, 1);
        check("a_data1", imem_wdata, 32'h00100593);
        tick();
        check("a_done", done, 1);
        check("a_core_rst", core_rst, 0);
        check("a_busy_done", busy, 0);
        check("a_we_done", imem_we, 0);
        check("a_wc_done", word_count, 2);
        check("a_writes", wr_count - wr_base, 2);

        // Empty program.
        wr_base = wr_count;
        pulse_start();
        check("b_core_rst_hdr", core_rst, 1);
        send_byte(8'h00); send_byte(8'h00);
        check("b_done", done, 1);
        check("b_core_rst", core_rst, 0);
        check("b_word_count", word_count, 0);
        check("b_writes", wr_count - wr_base, 0);

        // Oversized header (257 words) is rejected, then restart.
        pulse_start();
        send_byte(8'h01); send_byte(8'h01);
        check("c_error", error, 1);
        check("c_core_rst", core_rst, 1);
        check("c_byte_ready", byte_ready, 0);
        check("c_busy", busy, 0);
        check("c_word_count", word_count, 257);
        tick();
        check("c_error_held", error, 1);
        pulse_start();
        check("c_restart_busy", busy, 1);
        check("c_restart_ready", byte_ready, 1);
        check("c_restart_error", error, 0);

        // N=1 with stalls; word_count keeps the old header until HDR1 completes.
        wr_base = wr_count;
        send_byte(8'h01);
        tick(); tick(); tick();
        check("d_stall_busy", busy, 1);
        check("d_stall_ready", byte_ready, 1);
        check("d_stall_wc", word_count, 257);
        send_byte(8'h00);
        check("d_word_count", word_count, 1);
        send_byte(8'hEF); tick();
        send_byte(8'hBE); tick();
        send_byte(8'hAD); tick();
        check("d_stall_no_we", imem_we, 0);
        send_byte(8'hDE);
        check("d_we", imem_we, 1);
        check("d_addr", imem_addr, 0);
        check("d_data", imem_wdata, 32'hDEADBEEF);
        tick();
        check("d_done", done, 1);
        check("d_writes", wr_count - wr_base, 1);

        // Reset after the second data byte, then a clean reload.
        wr_base = wr_count;
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("e_core_rst", core_rst, 1);
        check("e_busy", busy, 0);
        check("e_ready", byte_ready, 0);
        check("e_word_count", word_count, 0);
        tick();
        check("e_idle_busy", busy, 0);
        check("e_writes_abort", wr_count - wr_base, 0);
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'h12345678);
        check("e_we", imem_we, 1);
        check("e_addr", imem_addr, 0);
        check("e_data", imem_wdata, 32'h12345678);
        tick();
        check("e_done", done, 1);
        check("e_writes", wr_count - wr_base, 1);

        // start pulsed mid-word is ignored.
        wr_base = wr_count;
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        pulse_start();
        check("f_busy", busy, 1);
        check("f_ready", byte_ready, 1);
        check("f_done", done, 0);
        send_byte(8'h33); send_byte(8'h44);
        check("f_addr0", imem_addr, 0);
        check("f_data0", imem_wdata, 32'h44332211);
        send_word(32'hCAFEF00D);
        check("f_addr1", imem_addr, 1);
        check("f_data1", imem_wdata, 32'hCAFEF00D);
        tick();
        check("f_done_end", done, 1);
        check("f_word_count", word_count, 2);
        check("f_writes", wr_count - wr_base, 2);

        // Reset landing on the WRITE cycle must suppress the strobe.
        wr_base = wr_count;
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'hDDCCBBAA);
        check("r_we_before", imem_we, 1);
        rst = 1'b1;
        #1;
        check("r_we_gated", imem_we, 0);
        check("r_addr_gated", imem_addr, 0);
        check("r_data_gated", imem_wdata, 0);
        tick();
        rst = 1'b0;
        check("r_writes", wr_count - wr_base, 0);
        check("r_core_rst", core_rst, 1);

        // Full 256-word image: addresses 0..255, no wrap, then DONE.
        wr_base = wr_count;
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        check("g_word_count", word_count, 256);
        for (int i = 0; i < 256; i++) begin
            send_word(32'hA5000000 | 32'(i));
            check("g_addr", imem_addr, 32'(i));
            check("g_data", imem_wdata, 32'hA5000000 | 32'(i));
        end
        tick();
        check("g_done", done, 1);
        check("g_core_rst", core_rst, 0);
        check("g_error", error, 0);
        check("g_writes", wr_count - wr_base, 256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
